// File: rtl/alu_decode_pipe_pkg.sv
// Opcode constants, ALU op encoding, decoded-entry layout and the pure decode
// function shared by the decode pipeline and its output FIFO.
package alu_pkg;

  localparam logic [4:0] OPC_ADD  = 5'h00;
  localparam logic [4:0] OPC_ADDI = 5'h01;
  localparam logic [4:0] OPC_SUB  = 5'h03;
  localparam logic [4:0] OPC_SUBI = 5'h04;
  localparam logic [4:0] OPC_AND  = 5'h05;
  localparam logic [4:0] OPC_OR   = 5'h06;
  localparam logic [4:0] OPC_XOR  = 5'h07;
  localparam logic [4:0] OPC_NOT  = 5'h08;
  localparam logic [4:0] OPC_JMPI = 5'h09;
  localparam logic [4:0] OPC_CLR  = 5'h0B;
  localparam logic [4:0] OPC_NOP  = 5'h0C;
  localparam logic [4:0] OPC_CMPE = 5'h12;
  localparam logic [4:0] OPC_CMPG = 5'h13;
  localparam logic [4:0] OPC_CMPL = 5'h14;
  localparam logic [4:0] OPC_SHRA = 5'h15;
  localparam logic [4:0] OPC_SHRL = 5'h16;
  localparam logic [4:0] OPC_SHL  = 5'h17;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOT  = 4'd5,
    ALU_CLR  = 4'd6,
    ALU_CMPE = 4'd7,
    ALU_CMPG = 4'd8,
    ALU_CMPL = 4'd9,
    ALU_SHRA = 4'd10,
    ALU_SHRL = 4'd11,
    ALU_SHL  = 4'd12,
    ALU_JMPI = 4'd13,
    ALU_NOP  = 4'd15
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    imm_sel;
    logic    err;
  } alu_dec_t;

  // hi_bad flags nonzero opcode bits above bit 4; those always decode as errors.
  function automatic alu_dec_t alu_decode(input logic [4:0] opc, input logic hi_bad);
    alu_dec_t d;
    d.op      = ALU_NOP;
    d.imm_sel = 1'b0;
    d.err     = 1'b0;
    case (opc)
      OPC_ADD:  d.op = ALU_ADD;
      OPC_ADDI: begin d.op = ALU_ADD; d.imm_sel = 1'b1; end
      OPC_SUB:  d.op = ALU_SUB;
      OPC_SUBI: begin d.op = ALU_SUB; d.imm_sel = 1'b1; end
      OPC_AND:  d.op = ALU_AND;
      OPC_OR:   d.op = ALU_OR;
      OPC_XOR:  d.op = ALU_XOR;
      OPC_NOT:  d.op = ALU_NOT;
      OPC_JMPI: d.op = ALU_JMPI;
      OPC_CLR:  d.op = ALU_CLR;
      OPC_NOP:  d.op = ALU_NOP;
      OPC_CMPE: d.op = ALU_CMPE;
      OPC_CMPG: d.op = ALU_CMPG;
      OPC_CMPL: d.op = ALU_CMPL;
      OPC_SHRA: d.op = ALU_SHRA;
      OPC_SHRL: d.op = ALU_SHRL;
      OPC_SHL:  d.op = ALU_SHL;
      default:  d.err = 1'b1;
    endcase
    if (hi_bad) begin
      d.op      = ALU_NOP;
      d.imm_sel = 1'b0;
      d.err     = 1'b1;
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_decode_pipe_if.sv
// Opcode-in / decoded-op-out handshake bundle plus flush and error status.
interface alu_decode_pipe_if #(
  parameter int OP_W      = 5,
  parameter int ALU_OP_W  = 4,
  parameter int ERR_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [OP_W-1:0]      in_op;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [ALU_OP_W-1:0]  out_alu_op;
  logic                 out_imm_sel;
  logic                 out_err;
  logic                 err_clr;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;

  // Upstream/ALU side: drives opcodes, consumes decoded ops.
  modport master (
    output in_valid, in_op, flush, out_ready, err_clr,
    input  in_ready, out_valid, out_alu_op, out_imm_sel, out_err, err_sticky, err_count
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_op, flush, out_ready, err_clr,
    output in_ready, out_valid, out_alu_op, out_imm_sel, out_err, err_sticky, err_count
  );
endinterface

// File: rtl/alu_decode_pipe_fifo.sv
// Small circular FIFO of decoded entries: wrap-around pointers, occupancy
// counter, synchronous flush that also discards a same-cycle push.
module alu_dec_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush_i,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic valid_o,
  output logic not_full_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T               mem_q [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push    = push_i && !flush_i;
  assign do_pop     = pop_i && valid_o;
  assign valid_o    = (count_q != '0);
  assign not_full_o = (count_q < CW'(DEPTH));
  assign dout_o     = mem_q[rptr_q];

  // Next pointers and occupancy; flush returns everything to the empty state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = bump(wptr_q);
      if (do_pop)  rptr_d = bump(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage cells; reset to zero so the head reads as an all-zero entry when empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               mem_q[gi] <= '0;
      else if (do_push && wptr_q == PW'(gi))    mem_q[gi] <= din_i;
    end
  end
endmodule

// File: rtl/alu_decode_pipe.sv
// Registered opcode decoder: decode on accept, buffer in the output FIFO,
// and keep sticky/saturating error status for accepted errored opcodes.
module alu_decode_pipe
  import alu_pkg::*;
#(
  parameter int OP_W      = 5,
  parameter int ALU_OP_W  = 4,
  parameter int DEPTH     = 2,
  parameter int ERR_CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  alu_decode_pipe_if.slave bus
);
  alu_dec_t             dec, head;
  logic                 hi_bad, accept, push_kept, err_hit;
  logic                 fifo_not_full, fifo_valid;
  logic [3:0]           head_op;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  if (OP_W > 5) begin : g_hi
    assign hi_bad = |bus.in_op[OP_W-1:5];
  end else begin : g_no_hi
    assign hi_bad = 1'b0;
  end

  assign dec       = alu_decode(bus.in_op[4:0], hi_bad);
  // A pop at full frees a slot in the same cycle, so out_ready opens the input.
  assign bus.in_ready = fifo_not_full || bus.out_ready;
  assign accept    = bus.in_valid && bus.in_ready;
  assign push_kept = accept && !bus.flush;
  assign err_hit   = push_kept && dec.err;

  alu_dec_fifo #(.DEPTH(DEPTH), .T(alu_dec_t)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.flush),
    .push_i     (accept),
    .din_i      (dec),
    .pop_i      (bus.out_ready),
    .dout_o     (head),
    .valid_o    (fifo_valid),
    .not_full_o (fifo_not_full)
  );

  assign head_op         = head.op;
  assign bus.out_valid   = fifo_valid;
  assign bus.out_alu_op  = ALU_OP_W'(head_op);
  assign bus.out_imm_sel = head.imm_sel;
  assign bus.out_err     = head.err;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.err_count   = err_cnt_q;

  // Error status next state; a clear coinciding with a new error leaves exactly that one.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (bus.err_clr) begin
      err_sticky_d = err_hit;
      err_cnt_d    = err_hit ? ERR_CNT_W'(1) : '0;
    end else if (err_hit) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe (OP_W=8, DEPTH=2, ERR_CNT_W=2): table-driven decode
// vectors through a scoreboard queue, plus hand sequences for backpressure,
// error clear, flush and asynchronous reset.
module tb_alu_decode_pipe;
  typedef struct {
    logic [7:0] opc;
    logic [3:0] op;
    logic       imm;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] op;
    logic       imm;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[22];

  alu_decode_pipe_if #(.OP_W(8), .ALU_OP_W(4), .ERR_CNT_W(2)) bus ();

  alu_decode_pipe #(.OP_W(8), .ALU_OP_W(4), .DEPTH(2), .ERR_CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: compare every pop against the oldest expected entry.
  always @(posedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("pop_underflow", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("pop alu_op=%0d imm=%0d err=%0d", bus.out_alu_op, bus.out_imm_sel, bus.out_err);
        check("out_alu_op", int'(bus.out_alu_op), int'(mon_e.op));
        check("out_imm_sel", int'(bus.out_imm_sel), int'(mon_e.imm));
        check("out_err", int'(bus.out_err), int'(mon_e.err));
      end
    end
  end

  // Offer one opcode, wait (bounded) for acceptance, record its expected decode.
  task automatic send(input logic [7:0] opc, input logic [3:0] op, input logic imm, input logic err);
    int   n;
    exp_t x;
    bus.in_valid = 1'b1;
    bus.in_op    = opc;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    x.op = op; x.imm = imm; x.err = err;
    if (!bus.flush) exp_q.push_back(x);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    $display("push in_op=%02h flush=%0d", opc, bus.flush);
  endtask

  task automatic set_vec(input int i, input logic [7:0] opc, input logic [3:0] op,
                         input logic imm, input logic err);
    vecs[i].opc = opc; vecs[i].op = op; vecs[i].imm = imm; vecs[i].err = err;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    int n_err;
    checks = 0; failures = 0;

    set_vec(0,  8'h01, 4'd0,  1'b1, 1'b0);
    set_vec(1,  8'h03, 4'd1,  1'b0, 1'b0);
    set_vec(2,  8'h17, 4'd12, 1'b0, 1'b0);
    set_vec(3,  8'h00, 4'd0,  1'b0, 1'b0);
    set_vec(4,  8'h04, 4'd1,  1'b1, 1'b0);
    set_vec(5,  8'h05, 4'd2,  1'b0, 1'b0);
    set_vec(6,  8'h06, 4'd3,  1'b0, 1'b0);
    set_vec(7,  8'h07, 4'd4,  1'b0, 1'b0);
    set_vec(8,  8'h08, 4'd5,  1'b0, 1'b0);
    set_vec(9,  8'h09, 4'd13, 1'b0, 1'b0);
    set_vec(10, 8'h0B, 4'd6,  1'b0, 1'b0);
    set_vec(11, 8'h0C, 4'd15, 1'b0, 1'b0);
    set_vec(12, 8'h0A, 4'd15, 1'b0, 1'b1);
    set_vec(13, 8'h12, 4'd7,  1'b0, 1'b0);
    set_vec(14, 8'h1F, 4'd15, 1'b0, 1'b1);
    set_vec(15, 8'h13, 4'd8,  1'b0, 1'b0);
    set_vec(16, 8'h25, 4'd15, 1'b0, 1'b1);
    set_vec(17, 8'h14, 4'd9,  1'b0, 1'b0);
    set_vec(18, 8'h15, 4'd10, 1'b0, 1'b0);
    set_vec(19, 8'h16, 4'd11, 1'b0, 1'b0);
    set_vec(20, 8'h02, 4'd15, 1'b0, 1'b1);
    set_vec(21, 8'h0D, 4'd15, 1'b0, 1'b1);

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.flush = 1'b0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_alu_op", int'(bus.out_alu_op), 0);
    check("rst_out_imm_sel", int'(bus.out_imm_sel), 0);
    check("rst_out_err", int'(bus.out_err), 0);
    check("rst_err_sticky", int'(bus.err_sticky), 0);
    check("rst_err_count", int'(bus.err_count), 0);
    check("rst_in_ready", int'(bus.in_ready), 1);

    // Decode table, back to back with out_ready=1: one-cycle latency, saturating count.
    bus.out_ready = 1'b1;
    n_err = 0;
    for (int i = 0; i < 22; i++) begin
      send(vecs[i].opc, vecs[i].op, vecs[i].imm, vecs[i].err);
      if (vecs[i].err) n_err = (n_err == 3) ? 3 : n_err + 1;
      check("lat_out_valid", int'(bus.out_valid), 1);
      check("err_count", int'(bus.err_count), n_err);
      check("err_sticky", int'(bus.err_sticky), (n_err != 0) ? 1 : 0);
    end
    @(posedge clk); #1;
    check("drain_out_valid", int'(bus.out_valid), 0);
    check("drain_queue_empty", exp_q.size(), 0);

    // Clear together with an errored accept, then clear alone.
    bus.err_clr = 1'b1;
    send(8'h0A, 4'd15, 1'b0, 1'b1);
    bus.err_clr = 1'b0;
    check("clr_hit_count", int'(bus.err_count), 1);
    check("clr_hit_sticky", int'(bus.err_sticky), 1);
    bus.err_clr = 1'b1;
    @(posedge clk); #1;
    bus.err_clr = 1'b0;
    check("clr_count", int'(bus.err_count), 0);
    check("clr_sticky", int'(bus.err_sticky), 0);

    // Backpressure: fill, stall, then push and pop in the same cycle.
    bus.out_ready = 1'b0;
    send(8'h03, 4'd1, 1'b0, 1'b0);
    send(8'h00, 4'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op = 8'h05;
    #1;
    check("full_in_ready", int'(bus.in_ready), 0);
    @(posedge clk); #1;
    check("stall_in_ready", int'(bus.in_ready), 0);
    check("stall_out_valid", int'(bus.out_valid), 1);
    check("stall_head_op", int'(bus.out_alu_op), 1);
    bus.out_ready = 1'b1;
    #1;
    check("full_pop_in_ready", int'(bus.in_ready), 1);
    mon_e.op = 4'd2; mon_e.imm = 1'b0; mon_e.err = 1'b0;
    exp_q.push_back(mon_e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    $display("push in_op=05 flush=0 (simultaneous pop)");
    repeat (3) @(posedge clk);
    #1;
    check("bp_drain_valid", int'(bus.out_valid), 0);
    check("bp_queue_empty", exp_q.size(), 0);

    // Flush with two buffered entries and a concurrent errored push.
    bus.out_ready = 1'b0;
    send(8'h00, 4'd0, 1'b0, 1'b0);
    send(8'h07, 4'd4, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = 8'h1F;
    #1;
    check("flush_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    exp_q.delete();
    $display("push in_op=1f flush=1 (discarded)");
    check("flush_out_valid", int'(bus.out_valid), 0);
    check("flush_err_count", int'(bus.err_count), 0);
    check("flush_err_sticky", int'(bus.err_sticky), 0);
    send(8'h06, 4'd3, 1'b0, 1'b0);
    check("post_flush_valid", int'(bus.out_valid), 1);
    check("post_flush_op", int'(bus.out_alu_op), 3);
    @(posedge clk); #1;

    // Asynchronous reset with a full FIFO and live error state.
    bus.out_ready = 1'b0;
    send(8'h0A, 4'd15, 1'b0, 1'b1);
    send(8'h01, 4'd0, 1'b1, 1'b0);
    check("pre_rst_count", int'(bus.err_count), 1);
    check("pre_rst_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(bus.out_valid), 0);
    check("arst_out_alu_op", int'(bus.out_alu_op), 0);
    check("arst_out_err", int'(bus.out_err), 0);
    check("arst_err_sticky", int'(bus.err_sticky), 0);
    check("arst_err_count", int'(bus.err_count), 0);
    check("arst_in_ready", int'(bus.in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(8'h16, 4'd11, 1'b0, 1'b0);
    check("post_rst_valid", int'(bus.out_valid), 1);
    @(posedge clk); #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
